div_ctrl: RTL and testbench

Sequencing controller for the two Xilinx divider cores (signed `div_gen_0`, unsigned `div_gen_1`) used by the execute stage. It accepts one divide request at a time, latches the operands, and drives the dividend and divisor AXI-stream channels of the selected core with independent handshakes. It captures the 64-bit result, selects the quotient or remainder, and holds the 32-bit result until the pipeline consumes it. It also handles pipeline cancellation without desynchronising the cores.

---
 rtl/div_ctrl.sv | 163 ++++++++++++++++
 tb/tb_div_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Sequencer for the signed (div_gen_0) and unsigned (div_gen_1) divider cores.
// Takes one request at a time, feeds both operand channels, and holds the selected result.
module div_ctrl #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_signed,
  input  logic            req_rem,
  input  logic [DW-1:0]   req_src1,
  input  logic [DW-1:0]   req_src2,
  input  logic            cancel,
  output logic            res_valid,
  output logic [DW-1:0]   res_data,
  input  logic            res_ready,
  output logic [DW-1:0]   div_dividend,
  output logic [DW-1:0]   div_divisor,
  output logic            s_dvd_tvalid,
  input  logic            s_dvd_tready,
  output logic            s_dvs_tvalid,
  input  logic            s_dvs_tready,
  input  logic            s_dout_tvalid,
  input  logic [2*DW-1:0] s_dout_tdata,
  output logic            u_dvd_tvalid,
  input  logic            u_dvd_tready,
  output logic            u_dvs_tvalid,
  input  logic            u_dvs_tready,
  input  logic            u_dout_tvalid,
  input  logic [2*DW-1:0] u_dout_tdata,
  output logic            err_spurious
);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic            signed_q, signed_d;
  logic            rem_q, rem_d;
  logic [DW-1:0]   dividend_q, dividend_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic [DW-1:0]   res_q, res_d;
  logic            dvd_sent_q, dvd_sent_d;
  logic            dvs_sent_q, dvs_sent_d;
  logic            kill_q, kill_d;
  logic            err_q, err_d;

  logic            dvd_tvalid, dvs_tvalid;
  logic            dvd_tready_sel, dvs_tready_sel;
  logic            dout_valid_sel;
  logic [2*DW-1:0] dout_data_sel;
  logic            dvd_done, dvs_done;
  logic            expect_s, expect_u, spurious;

  // Channel valids come from registered state and flags only.
  assign dvd_tvalid = (state_q == StSend) && !dvd_sent_q;
  assign dvs_tvalid = (state_q == StSend) && !dvs_sent_q;

  assign dvd_tready_sel = signed_q ? s_dvd_tready  : u_dvd_tready;
  assign dvs_tready_sel = signed_q ? s_dvs_tready  : u_dvs_tready;
  assign dout_valid_sel = signed_q ? s_dout_tvalid : u_dout_tvalid;
  assign dout_data_sel  = signed_q ? s_dout_tdata  : u_dout_tdata;

  // Sent flags including a handshake happening this cycle.
  assign dvd_done = dvd_sent_q || (dvd_tvalid && dvd_tready_sel);
  assign dvs_done = dvs_sent_q || (dvs_tvalid && dvs_tready_sel);

  assign expect_s = (state_q == StWait) && signed_q;
  assign expect_u = (state_q == StWait) && !signed_q;
  assign spurious = (s_dout_tvalid && !expect_s) || (u_dout_tvalid && !expect_u);

  always_comb begin
    state_d    = state_q;
    signed_d   = signed_q;
    rem_d      = rem_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    res_d      = res_q;
    dvd_sent_d = dvd_sent_q;
    dvs_sent_d = dvs_sent_q;
    kill_d     = kill_q;
    err_d      = err_q || spurious;

    case (state_q)
      StIdle: begin
        if (req_valid && !cancel) begin
          state_d    = StSend;
          signed_d   = req_signed;
          rem_d      = req_rem;
          dividend_d = req_src1;
          divisor_d  = req_src2;
          dvd_sent_d = 1'b0;
          dvs_sent_d = 1'b0;
          kill_d     = 1'b0;
        end
      end
      StSend: begin
        dvd_sent_d = dvd_done;
        dvs_sent_d = dvs_done;
        if (cancel && !dvd_done && !dvs_done) begin
          state_d = StIdle;
        end else begin
          // A core that saw any operand must see both, so a late cancel only marks the op dead.
          if (cancel) kill_d = 1'b1;
          if (dvd_done && dvs_done) state_d = StWait;
        end
      end
      StWait: begin
        if (cancel) kill_d = 1'b1;
        if (dout_valid_sel) begin
          if (kill_q || cancel) begin
            state_d = StIdle;
          end else begin
            res_d   = rem_q ? dout_data_sel[DW-1:0] : dout_data_sel[2*DW-1:DW];
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (res_ready || cancel) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      signed_q   <= 1'b0;
      rem_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      res_q      <= '0;
      dvd_sent_q <= 1'b0;
      dvs_sent_q <= 1'b0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      signed_q   <= signed_d;
      rem_q      <= rem_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      res_q      <= res_d;
      dvd_sent_q <= dvd_sent_d;
      dvs_sent_q <= dvs_sent_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign res_valid    = (state_q == StDone);
  assign res_data     = res_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign s_dvd_tvalid = dvd_tvalid && signed_q;
  assign s_dvs_tvalid = dvs_tvalid && signed_q;
  assign u_dvd_tvalid = dvd_tvalid && !signed_q;
  assign u_dvs_tvalid = dvs_tvalid && !signed_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: transaction-level model of the controller plus simple divider-core models,
// compared against the DUT on every cycle, with directed literal cases and a random phase.
module tb_div_ctrl;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn, req_valid, req_ready, req_signed, req_rem, cancel;
  logic [DW-1:0]   req_src1, req_src2, res_data, div_dividend, div_divisor;
  logic            res_valid, res_ready, err_spurious;
  logic            s_dvd_tvalid, s_dvd_tready, s_dvs_tvalid, s_dvs_tready, s_dout_tvalid;
  logic            u_dvd_tvalid, u_dvd_tready, u_dvs_tvalid, u_dvs_tready, u_dout_tvalid;
  logic [2*DW-1:0] s_dout_tdata, u_dout_tdata;

  div_ctrl #(.DW(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_signed   (req_signed),
    .req_rem      (req_rem),
    .req_src1     (req_src1),
    .req_src2     (req_src2),
    .cancel       (cancel),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .s_dvd_tvalid (s_dvd_tvalid),
    .s_dvd_tready (s_dvd_tready),
    .s_dvs_tvalid (s_dvs_tvalid),
    .s_dvs_tready (s_dvs_tready),
    .s_dout_tvalid(s_dout_tvalid),
    .s_dout_tdata (s_dout_tdata),
    .u_dvd_tvalid (u_dvd_tvalid),
    .u_dvd_tready (u_dvd_tready),
    .u_dvs_tvalid (u_dvs_tvalid),
    .u_dvs_tready (u_dvs_tready),
    .u_dout_tvalid(u_dout_tvalid),
    .u_dout_tdata (u_dout_tdata),
    .err_spurious (err_spurious)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level model of the controller.
  bit            m_busy, m_sgn, m_rem, m_dvd_sent, m_dvs_sent, m_kill, m_have_res, m_err;
  logic [DW-1:0] m_a, m_b, m_res;

  // Core models: operand beats queue up, results appear core_lat cycles after the pair completes.
  logic [DW-1:0]   s_dvd_q[$], s_dvs_q[$], u_dvd_q[$], u_dvs_q[$];
  logic [2*DW-1:0] s_out_q[$], u_out_q[$];
  int              s_due_q[$], u_due_q[$];
  int              core_lat = 3;
  bit              inj_s = 0, inj_u = 0;

  int n_s_dvd_beat, n_s_dvs_beat, n_u_beat, n_s_dvd_tv, n_s_dvs_tv, n_u_tv, n_resv, n_results;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2*DW-1:0] div_ref(input bit sgn, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    logic signed [DW-1:0] sa, sb;
    logic [DW-1:0]        q, r;
    sa = a;
    sb = b;
    if (b == '0) return {{DW{1'b1}}, a};
    if (sgn) begin
      if (a == {1'b1, {(DW-1){1'b0}}} && b == {DW{1'b1}}) return {a, {DW{1'b0}}};
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic clear_stats();
    n_s_dvd_beat = 0; n_s_dvs_beat = 0; n_u_beat = 0;
    n_s_dvd_tv = 0; n_s_dvs_tv = 0; n_u_tv = 0; n_resv = 0; n_results = 0;
  endtask

  task automatic flush_cores();
    s_dvd_q.delete(); s_dvs_q.delete(); u_dvd_q.delete(); u_dvs_q.delete();
    s_out_q.delete(); u_out_q.delete(); s_due_q.delete(); u_due_q.delete();
  endtask

  // One cycle: compare outputs, drive core outputs, advance the models over the coming edge.
  task automatic step();
    bit              exp_dvd, exp_dvs, waiting, sv, uv, dv, tr_dvd, tr_dvs, nd, ns, acc;
    logic [2*DW-1:0] sd, ud;
    exp_dvd = m_busy && !m_dvd_sent;
    exp_dvs = m_busy && !m_dvs_sent;
    check("req_ready", req_ready, !m_busy);
    check("res_valid", res_valid, m_have_res);
    check("res_data", res_data, m_res);
    check("s_dvd_tvalid", s_dvd_tvalid, exp_dvd && m_sgn);
    check("s_dvs_tvalid", s_dvs_tvalid, exp_dvs && m_sgn);
    check("u_dvd_tvalid", u_dvd_tvalid, exp_dvd && !m_sgn);
    check("u_dvs_tvalid", u_dvs_tvalid, exp_dvs && !m_sgn);
    check("div_dividend", div_dividend, m_a);
    check("div_divisor", div_divisor, m_b);
    check("err_spurious", err_spurious, m_err);
    if (s_dvd_tvalid) n_s_dvd_tv++;
    if (s_dvs_tvalid) n_s_dvs_tv++;
    if (u_dvd_tvalid || u_dvs_tvalid) n_u_tv++;
    if (res_valid) n_resv++;

    if (!resetn) begin
      flush_cores();
      s_dout_tvalid = 1'b0; s_dout_tdata = '0;
      u_dout_tvalid = 1'b0; u_dout_tdata = '0;
      m_busy = 0; m_sgn = 0; m_rem = 0; m_dvd_sent = 0; m_dvs_sent = 0;
      m_kill = 0; m_have_res = 0; m_err = 0; m_a = '0; m_b = '0; m_res = '0;
      cyc++;
      @(negedge clk);
      return;
    end

    sv = 0; uv = 0; sd = '0; ud = '0;
    if (s_due_q.size() > 0 && s_due_q[0] <= cyc) begin
      sv = 1; sd = s_out_q.pop_front(); void'(s_due_q.pop_front());
    end
    if (u_due_q.size() > 0 && u_due_q[0] <= cyc) begin
      uv = 1; ud = u_out_q.pop_front(); void'(u_due_q.pop_front());
    end
    if (inj_s) begin sv = 1; sd = 64'hDEAD_BEEF_CAFE_F00D; end
    if (inj_u) begin uv = 1; ud = 64'h0BAD_0BAD_1234_5678; end
    s_dout_tvalid = sv; s_dout_tdata = sd;
    u_dout_tvalid = uv; u_dout_tdata = ud;

    // Core side reacts to what the DUT actually drives.
    if (s_dvd_tvalid && s_dvd_tready) begin s_dvd_q.push_back(div_dividend); n_s_dvd_beat++; end
    if (s_dvs_tvalid && s_dvs_tready) begin s_dvs_q.push_back(div_divisor); n_s_dvs_beat++; end
    if (u_dvd_tvalid && u_dvd_tready) begin u_dvd_q.push_back(div_dividend); n_u_beat++; end
    if (u_dvs_tvalid && u_dvs_tready) begin u_dvs_q.push_back(div_divisor); n_u_beat++; end
    while (s_dvd_q.size() > 0 && s_dvs_q.size() > 0) begin
      s_out_q.push_back(div_ref(1'b1, s_dvd_q.pop_front(), s_dvs_q.pop_front()));
      s_due_q.push_back(cyc + core_lat);
    end
    while (u_dvd_q.size() > 0 && u_dvs_q.size() > 0) begin
      u_out_q.push_back(div_ref(1'b0, u_dvd_q.pop_front(), u_dvs_q.pop_front()));
      u_due_q.push_back(cyc + core_lat);
    end

    waiting = m_busy && m_dvd_sent && m_dvs_sent && !m_have_res;
    if ((sv && !(waiting && m_sgn)) || (uv && !(waiting && !m_sgn))) m_err = 1;
    acc = !m_busy && req_valid && !cancel;
    if (m_busy) begin
      if (m_have_res) begin
        if (res_ready || cancel) begin m_busy = 0; m_have_res = 0; end
      end else if (!waiting) begin
        tr_dvd = m_sgn ? s_dvd_tready : u_dvd_tready;
        tr_dvs = m_sgn ? s_dvs_tready : u_dvs_tready;
        nd = m_dvd_sent || tr_dvd;
        ns = m_dvs_sent || tr_dvs;
        if (cancel && !nd && !ns) m_busy = 0;
        else begin
          if (cancel) m_kill = 1;
          m_dvd_sent = nd;
          m_dvs_sent = ns;
        end
      end else begin
        dv = m_sgn ? sv : uv;
        if (cancel) m_kill = 1;
        if (dv) begin
          if (m_kill) m_busy = 0;
          else begin
            m_have_res = 1;
            sd = div_ref(m_sgn, m_a, m_b);
            m_res = m_rem ? sd[DW-1:0] : sd[2*DW-1:DW];
            n_results++;
          end
        end
      end
    end else if (acc) begin
      m_busy = 1; m_sgn = req_signed; m_rem = req_rem; m_a = req_src1; m_b = req_src2;
      m_dvd_sent = 0; m_dvs_sent = 0; m_kill = 0; m_have_res = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_ready(input bit v);
    s_dvd_tready = v; s_dvs_tready = v; u_dvd_tready = v; u_dvs_tready = v;
  endtask

  task automatic issue(input bit sgn, input bit rem, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    req_valid = 1; req_signed = sgn; req_rem = rem; req_src1 = a; req_src2 = b;
    step();
    req_valid = 0;
  endtask

  task automatic wait_res();
    for (int i = 0; i < 60 && !res_valid; i++) step();
    check("result_timeout", res_valid, 1'b1);
  endtask

  task automatic consume();
    res_ready = 1; step(); res_ready = 0;
  endtask

  task automatic run_op(input string name, input bit sgn, input bit rem,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] lit);
    clear_stats();
    set_ready(1);
    issue(sgn, rem, a, b);
    wait_res();
    check(name, res_data, lit);
    check({name, "_own_beats"}, sgn ? n_s_dvd_beat + n_s_dvs_beat : n_u_beat, 2);
    check({name, "_other_tv"}, sgn ? n_u_tv : n_s_dvd_tv + n_s_dvs_tv, 0);
    consume();
  endtask

  initial begin
    resetn = 0; req_valid = 0; req_signed = 0; req_rem = 0; req_src1 = '0; req_src2 = '0;
    cancel = 0; res_ready = 0; set_ready(0);
    s_dout_tvalid = 0; s_dout_tdata = '0; u_dout_tvalid = 0; u_dout_tdata = '0;
    repeat (2) @(negedge clk);
    step();
    resetn = 1;
    step();

    run_op("signed_quot", 1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("signed_rem", 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("unsigned_quot", 0, 0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    run_op("unsigned_rem", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);
    run_op("div_by_zero", 0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF);

    // Staggered channel readiness.
    clear_stats();
    set_ready(0); s_dvd_tready = 1;
    issue(1, 0, 32'd100, 32'd7);
    step();
    s_dvd_tready = 0;
    step(); step();
    s_dvs_tready = 1;
    step();
    check("stagger_dvs_low", s_dvs_tvalid, 1'b0);
    check("stagger_dvd_cycles", n_s_dvd_tv, 1);
    check("stagger_dvs_cycles", n_s_dvs_tv, 4);
    wait_res();
    check("stagger_result", res_data, 32'd14);
    consume();

    // Backpressure in the done state.
    set_ready(1);
    issue(0, 1, 32'd100, 32'd7);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_res_data", res_data, 32'd2);
      check("bp_req_ready", req_ready, 1'b0);
    end
    consume();
    check("bp_release_ready", req_ready, 1'b1);

    // Cancel while waiting on the core.
    clear_stats();
    core_lat = 6;
    issue(1, 0, 32'd50, 32'd5);
    step();
    cancel = 1; step(); cancel = 0;
    repeat (10) step();
    check("cw_no_result", n_resv, 0);
    check("cw_err", err_spurious, 1'b0);
    check("cw_core_drained", s_out_q.size(), 0);

    // Cancel in send after only the dividend went out.
    clear_stats();
    core_lat = 3; set_ready(0); s_dvd_tready = 1;
    issue(1, 1, 32'd77, 32'd4);
    step();
    s_dvd_tready = 0; cancel = 1; step(); cancel = 0;
    step();
    s_dvs_tready = 1; step();
    repeat (10) step();
    check("cs_dvd_beats", n_s_dvd_beat, 1);
    check("cs_dvs_beats", n_s_dvs_beat, 1);
    check("cs_no_result", n_resv, 0);
    check("cs_idle", req_ready, 1'b1);
    check("cs_err", err_spurious, 1'b0);

    // Random traffic.
    clear_stats();
    for (int i = 0; i < 4000; i++) begin
      logic [DW-1:0] a, b;
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = $urandom_range(1, 9);
      if ($urandom_range(0, 15) == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 31) == 0) b = '0;
      req_valid = $urandom_range(0, 1); req_signed = $urandom_range(0, 1);
      req_rem = $urandom_range(0, 1); req_src1 = a; req_src2 = b;
      cancel = ($urandom_range(0, 24) == 0);
      res_ready = $urandom_range(0, 1);
      s_dvd_tready = ($urandom_range(0, 9) < 6); s_dvs_tready = ($urandom_range(0, 9) < 6);
      u_dvd_tready = ($urandom_range(0, 9) < 6); u_dvs_tready = ($urandom_range(0, 9) < 6);
      core_lat = $urandom_range(1, 5);
      step();
    end
    req_valid = 0; cancel = 0; res_ready = 1; set_ready(1);
    repeat (30) step();
    res_ready = 0;
    check("random_results_seen", n_results > 50, 1'b1);

    // Reset while waiting, then a fresh op, then an unsolicited core output.
    core_lat = 8;
    issue(1, 0, 32'd9, 32'd3);
    step();
    resetn = 0; step(); resetn = 1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_err", err_spurious, 1'b0);
    core_lat = 2;
    run_op("post_reset", 1, 0, 32'hFFFF_FF9C, 32'd10, 32'hFFFF_FFF6);
    check("pre_spurious_err", err_spurious, 1'b0);
    inj_u = 1; step(); inj_u = 0;
    step();
    check("spurious_err", err_spurious, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
